byte_lane_arbiter: RTL

BYTE_LANE_ARBITER -- requirements
Module: byte_lane_arbiter

---
 rtl/byte_lane_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/byte_lane_arbiter.sv
// Two-requester round-robin arbiter that serialises 32-bit words onto an 8-bit lane, MSB first.
// Optional parity output is enabled by defining LANE_PARITY_EN.
module byte_lane_arbiter (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic        req0,
  input  logic [31:0] data_in0,
  input  logic        req1,
  input  logic [31:0] data_in1,
  output logic        ack0,
  output logic        ack1,
  output logic        valid_out,
  output logic [7:0]  data_out,
  output logic [1:0]  sel,
  output logic        owner,
  output logic        busy
`ifdef LANE_PARITY_EN
  ,
  output logic        parity_out
`endif
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_cnt, w_cnt_d;
  logic [31:0] r_hold, w_hold_d;
  logic        r_last, w_last_d;

  logic        r_ack0, w_ack0_d;
  logic        r_ack1, w_ack1_d;
  logic        r_valid, w_valid_d;
  logic [7:0]  r_data, w_data_d;
  logic [1:0]  r_sel, w_sel_d;
  logic        r_owner, w_owner_d;
  logic        r_busy, w_busy_d;

  logic        w_arb;
  logic        w_grant;
  logic        w_win;
  logic [31:0] w_word;

  // Arbitration happens in IDLE and on the last byte, so back-to-back words have no bubble.
  assign w_arb   = (r_state == StIdle) || (r_cnt == 2'd3);
  assign w_grant = w_arb && (req0 || req1);
  // On contention the requester not granted last time wins.
  assign w_win   = (req0 && req1) ? ~r_last : req1;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_hold_d  = r_hold;
    w_last_d  = r_last;
    w_owner_d = r_owner;
    w_ack0_d  = 1'b0;
    w_ack1_d  = 1'b0;
    w_valid_d = 1'b0;
    w_busy_d  = 1'b0;
    w_data_d  = 8'h00;
    w_sel_d   = 2'd0;
    w_word    = r_hold;

    if (w_arb) begin
      w_cnt_d = 2'd0;
      if (w_grant) begin
        w_word    = w_win ? data_in1 : data_in0;
        w_state_d = StSend;
        w_hold_d  = w_word;
        w_last_d  = w_win;
        w_owner_d = w_win;
        w_ack0_d  = ~w_win;
        w_ack1_d  = w_win;
        w_valid_d = 1'b1;
        w_busy_d  = 1'b1;
        w_data_d  = w_word[31:24];
      end else begin
        w_state_d = StIdle;
      end
    end else begin
      w_cnt_d   = r_cnt + 2'd1;
      w_valid_d = 1'b1;
      w_busy_d  = 1'b1;
      w_sel_d   = w_cnt_d;
      unique case (w_cnt_d)
        2'd0:    w_data_d = r_hold[31:24];
        2'd1:    w_data_d = r_hold[23:16];
        2'd2:    w_data_d = r_hold[15:8];
        default: w_data_d = r_hold[7:0];
      endcase
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
      r_hold  <= 32'h0;
      r_last  <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_sel   <= 2'd0;
      r_owner <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_hold  <= w_hold_d;
      r_last  <= w_last_d;
      r_ack0  <= w_ack0_d;
      r_ack1  <= w_ack1_d;
      r_valid <= w_valid_d;
      r_data  <= w_data_d;
      r_sel   <= w_sel_d;
      r_owner <= w_owner_d;
      r_busy  <= w_busy_d;
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign sel       = r_sel;
  assign owner     = r_owner;
  assign busy      = r_busy;

`ifdef LANE_PARITY_EN
  logic r_parity;

  // Idle bytes are forced to zero, so their XOR is already zero.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ^w_data_d;
    end
  end

  assign parity_out = r_parity;
`endif

endmodule
